branch_resolve_unit: RTL and testbench

- Parametrised, pipelined successor to the single-cycle branch comparator. Resolves conditional branches, JAL and JALR: evaluates the condition, computes target/next-PC/link, and detects mispredicts against the front-end prediction.
- Two-stage pipeline with valid/ready handshakes on both sides, a flush input, and saturating branch/mispredict performance counters.
- Sits between the EX-stage operand muxes and the fetch redirect logic.

---
 rtl/branch_resolve_unit_if.sv | 46 ++++
 rtl/branch_resolve_unit.sv | 198 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle for the branch resolve unit.
// The master side is the EX-stage operand logic plus the redirect consumer.
// The slave side is the resolve unit itself.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  // Request side
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [2:0]       funct_b;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             flush;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic [XLEN-1:0]  next_pc;
  logic [XLEN-1:0]  link;
  logic             mispredict;
  logic             misaligned;
  logic             illegal;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output in_valid, op, funct_b, rs1, rs2, pc, imm, pred_taken, pred_target,
    output flush, out_ready,
    input  in_ready, out_valid, taken, next_pc, link, mispredict, misaligned,
    input  illegal, br_count, mp_count
  );

  modport slave (
    input  in_valid, op, funct_b, rs1, rs2, pc, imm, pred_taken, pred_target,
    input  flush, out_ready,
    output in_ready, out_valid, taken, next_pc, link, mispredict, misaligned,
    output illegal, br_count, mp_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Two-stage branch/jump resolver.
// S1 holds the raw request; the condition, target and mispredict logic runs
// between S1 and S2; S2 holds the result that drives every output.
// Also keeps saturating counters of retired branches and mispredicts.
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int IALIGN = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  branch_resolve_unit_if.slave    bus
);

  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_JAL  = 2'b01;
  localparam logic [1:0] OP_JALR = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam logic [2:0] FB_BEQ  = 3'b000;
  localparam logic [2:0] FB_BNE  = 3'b001;
  localparam logic [2:0] FB_BLT  = 3'b100;
  localparam logic [2:0] FB_BGE  = 3'b101;
  localparam logic [2:0] FB_BLTU = 3'b110;
  localparam logic [2:0] FB_BGEU = 3'b111;

  // Low target bits that must be zero for an aligned fetch.
  localparam logic [1:0] ALIGN_MASK = (IALIGN == 2) ? 2'b01 : 2'b11;

  // Stage 1: registered request
  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [2:0]       s1_funct;
  logic [XLEN-1:0]  s1_rs1;
  logic [XLEN-1:0]  s1_rs2;
  logic [XLEN-1:0]  s1_pc;
  logic [XLEN-1:0]  s1_imm;
  logic             s1_pred_taken;
  logic [XLEN-1:0]  s1_pred_target;

  // Stage 2: registered result
  logic             s2_valid;
  logic             s2_taken;
  logic [XLEN-1:0]  s2_next_pc;
  logic [XLEN-1:0]  s2_link;
  logic             s2_mispredict;
  logic             s2_misaligned;
  logic             s2_illegal;
  logic             s2_is_branch;

  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] mp_count_q;

  // Pipeline control
  logic s1_adv;
  logic s2_adv;
  logic accept;
  logic retire;

  // Resolution logic between S1 and S2
  logic             cond_c;
  logic             illegal_c;
  logic             taken_c;
  logic [XLEN-1:0]  jalr_sum_c;
  logic [XLEN-1:0]  target_c;
  logic [XLEN-1:0]  link_c;
  logic [XLEN-1:0]  next_pc_c;
  logic             mispredict_c;
  logic             misaligned_c;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;
  // A flush cycle neither accepts a new request nor retires the presented result.
  assign accept       = bus.in_valid && s1_adv && !bus.flush;
  assign retire       = s2_valid && bus.out_ready && !bus.flush;

  // S1 occupancy: refills whenever the stage can advance, emptied by flush
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
    end
  end

  // S1 payload: captured only on an accepted handshake
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op          <= bus.op;
      s1_funct       <= bus.funct_b;
      s1_rs1         <= bus.rs1;
      s1_rs2         <= bus.rs2;
      s1_pc          <= bus.pc;
      s1_imm         <= bus.imm;
      s1_pred_taken  <= bus.pred_taken;
      s1_pred_target <= bus.pred_target;
    end
  end

  // Evaluate condition, target, link and prediction check for the S1 request
  always_comb begin
    cond_c       = 1'b0;
    illegal_c    = 1'b0;
    taken_c      = 1'b0;
    jalr_sum_c   = s1_rs1 + s1_imm;
    target_c     = s1_pc + s1_imm;
    link_c       = s1_pc + XLEN'(4);

    case (s1_op)
      OP_BR: begin
        case (s1_funct)
          FB_BEQ:  cond_c = (s1_rs1 == s1_rs2);
          FB_BNE:  cond_c = (s1_rs1 != s1_rs2);
          FB_BLT:  cond_c = ($signed(s1_rs1) <  $signed(s1_rs2));
          FB_BGE:  cond_c = ($signed(s1_rs1) >= $signed(s1_rs2));
          FB_BLTU: cond_c = (s1_rs1 <  s1_rs2);
          FB_BGEU: cond_c = (s1_rs1 >= s1_rs2);
          default: illegal_c = 1'b1;
        endcase
        taken_c = cond_c;
      end
      OP_JAL: begin
        taken_c = 1'b1;
      end
      OP_JALR: begin
        taken_c  = 1'b1;
        target_c = {jalr_sum_c[XLEN-1:1], 1'b0};
      end
      default: begin
        taken_c = 1'b0;
      end
    endcase

    next_pc_c    = taken_c ? target_c : link_c;
    misaligned_c = taken_c && ((target_c[1:0] & ALIGN_MASK) != 2'b00);
    mispredict_c = 1'b0;
    if (!illegal_c && (s1_op != OP_NOP)) begin
      mispredict_c = (taken_c != s1_pred_taken) ||
                     (taken_c && (target_c != s1_pred_target));
    end
  end

  // S2 result register: holds while the consumer stalls, emptied by flush
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid      <= 1'b0;
      s2_taken      <= 1'b0;
      s2_next_pc    <= '0;
      s2_link       <= '0;
      s2_mispredict <= 1'b0;
      s2_misaligned <= 1'b0;
      s2_illegal    <= 1'b0;
      s2_is_branch  <= 1'b0;
    end else if (bus.flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_taken      <= taken_c;
        s2_next_pc    <= next_pc_c;
        s2_link       <= link_c;
        s2_mispredict <= mispredict_c;
        s2_misaligned <= misaligned_c;
        s2_illegal    <= illegal_c;
        s2_is_branch  <= (s1_op != OP_NOP);
      end
    end
  end

  // Saturating retire counters, advanced only on a completed output transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else if (retire) begin
      if (s2_is_branch && (br_count_q != '1)) begin
        br_count_q <= br_count_q + CNT_W'(1);
      end
      if (s2_mispredict && (mp_count_q != '1)) begin
        mp_count_q <= mp_count_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.taken      = s2_taken;
  assign bus.next_pc    = s2_next_pc;
  assign bus.link       = s2_link;
  assign bus.mispredict = s2_mispredict;
  assign bus.misaligned = s2_misaligned;
  assign bus.illegal    = s2_illegal;
  assign bus.br_count   = br_count_q;
  assign bus.mp_count   = mp_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit (XLEN=32, IALIGN=4, CNT_W=4).
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  fb;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pt;
    logic [31:0] ptgt;
  } req_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] next_pc;
    logic [31:0] link;
    logic        mp;
    logic        mis;
    logic        ill;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mp = 0;

  res_t sb[$];
  logic bq[$];

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .IALIGN(4), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic req_t mk(logic [1:0] op, logic [2:0] fb, logic [31:0] rs1,
                              logic [31:0] rs2, logic [31:0] pc, logic [31:0] imm,
                              logic pt, logic [31:0] ptgt);
    req_t r;
    r.op = op; r.fb = fb; r.rs1 = rs1; r.rs2 = rs2;
    r.pc = pc; r.imm = imm; r.pt = pt; r.ptgt = ptgt;
    return r;
  endfunction

  // Reference behaviour of one request
  function automatic res_t model(req_t r);
    res_t o;
    logic [31:0] tgt;
    logic t, il;
    t = 1'b0; il = 1'b0;
    tgt = r.pc + r.imm;
    if (r.op == 2'b00) begin
      case (r.fb)
        3'b000:  t = (r.rs1 == r.rs2);
        3'b001:  t = (r.rs1 != r.rs2);
        3'b100:  t = ($signed(r.rs1) < $signed(r.rs2));
        3'b101:  t = !($signed(r.rs1) < $signed(r.rs2));
        3'b110:  t = (r.rs1 < r.rs2);
        3'b111:  t = !(r.rs1 < r.rs2);
        default: il = 1'b1;
      endcase
    end else if (r.op == 2'b01) begin
      t = 1'b1;
    end else if (r.op == 2'b10) begin
      t = 1'b1;
      tgt = (r.rs1 + r.imm) & 32'hFFFF_FFFE;
    end
    o.taken   = t;
    o.link    = r.pc + 32'd4;
    o.next_pc = t ? tgt : o.link;
    o.ill     = il;
    o.mis     = t && ((tgt % 4) != 0);
    o.mp      = (!il && r.op != 2'b11) ? ((t != r.pt) || (t && tgt != r.ptgt)) : 1'b0;
    return o;
  endfunction

  function automatic res_t observed();
    res_t o;
    o.taken = bus.taken; o.next_pc = bus.next_pc; o.link = bus.link;
    o.mp = bus.mispredict; o.mis = bus.misaligned; o.ill = bus.illegal;
    return o;
  endfunction

  task automatic apply(req_t r, logic v);
    bus.in_valid    = v;
    bus.op          = r.op;
    bus.funct_b     = r.fb;
    bus.rs1         = r.rs1;
    bus.rs2         = r.rs2;
    bus.pc          = r.pc;
    bus.imm         = r.imm;
    bus.pred_taken  = r.pt;
    bus.pred_target = r.ptgt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply('0, 1'b0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete(); bq.delete();
    exp_br = 0; exp_mp = 0;
  endtask

  task automatic test_reset();
    res_t got;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    apply(mk(2'b01, 3'b000, 32'h1, 32'h2, 32'h40, 32'h8, 1'b0, 32'h0), 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    got = observed();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", got); end
    checks++;
    if (bus.br_count !== '0 || bus.mp_count !== '0) begin
      errors++; $display("FAIL reset_counters br=%0d mp=%0d want 0 0", bus.br_count, bus.mp_count);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    rst = 1'b0;
    apply('0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_leak out_valid got=%b want=0", bus.out_valid); end
    end
    sb.delete(); bq.delete();
    exp_br = 0; exp_mp = 0;
  endtask

  // Single blt: latency, values and counters
  task automatic test_single();
    req_t r;
    res_t e, got;
    do_reset();
    r = mk(2'b00, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
    @(negedge clk);
    apply(r, 1'b1); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b want=1", bus.in_ready); end
    sb.push_back(model(r));
    @(negedge clk);
    apply('0, 1'b0); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%b want=0", bus.out_valid); end
    @(negedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency out_valid got=%b want=1", bus.out_valid);
    end else begin
      e = sb.pop_front();
      got = observed();
      if (got !== e) begin errors++; $display("FAIL single_result got=%h want=%h", got, e); end
    end
    checks++;
    if (bus.taken !== 1'b1 || bus.next_pc !== 32'h120 || bus.mispredict !== 1'b1) begin
      errors++; $display("FAIL single_blt taken=%b next_pc=%h mp=%b want 1 00000120 1",
                         bus.taken, bus.next_pc, bus.mispredict);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.mp_count !== 4'd1 || bus.br_count !== 4'd1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_counters br=%0d mp=%0d ov=%b want 1 1 0",
                         bus.br_count, bus.mp_count, bus.out_valid);
    end
  endtask

  // Mixed conditions, jumps, no-op through a full-rate stream
  task automatic test_conditions();
    req_t rq[$];
    res_t e, got;
    logic b;
    int idx;
    do_reset();
    rq.push_back(mk(2'b00, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0));
    rq.push_back(mk(2'b00, 3'b000, 32'h5, 32'h5, 32'h300, 32'h40, 1'b1, 32'h340));
    rq.push_back(mk(2'b00, 3'b000, 32'h5, 32'h5, 32'h300, 32'h40, 1'b1, 32'h344));
    rq.push_back(mk(2'b00, 3'b001, 32'h5, 32'h5, 32'h310, 32'h40, 1'b1, 32'h350));
    rq.push_back(mk(2'b00, 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h320, 32'h10, 1'b0, 32'h0));
    rq.push_back(mk(2'b00, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h330, 32'h10, 1'b0, 32'h0));
    rq.push_back(mk(2'b01, 3'b000, 32'h0, 32'h0, 32'h400, 32'hFFFF_FFF8, 1'b1, 32'h3F8));
    rq.push_back(mk(2'b01, 3'b000, 32'h0, 32'h0, 32'h400, 32'h6, 1'b0, 32'h0));
    rq.push_back(mk(2'b10, 3'b000, 32'h1003, 32'h0, 32'h200, 32'h0, 1'b1, 32'h1002));
    rq.push_back(mk(2'b10, 3'b000, 32'h2000, 32'h0, 32'h210, 32'hFFFF_FFFF, 1'b1, 32'h1FFE));
    rq.push_back(mk(2'b11, 3'b000, 32'h0, 32'h0, 32'h500, 32'h40, 1'b1, 32'h540));
    rq.push_back(mk(2'b00, 3'b110, 32'h1, 32'hFFFF_FFFF, 32'h600, 32'hFFFF_FF00, 1'b1, 32'h500));
    idx = 0;
    for (int cyc = 0; cyc < 60 && (idx < rq.size() || sb.size() != 0); cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b1; #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        got = observed();
        if (sb.size() == 0) begin
          errors++; $display("FAIL cond_unexpected got=%h want=none", got);
        end else begin
          e = sb.pop_front(); b = bq.pop_front();
          if (got !== e) begin errors++; $display("FAIL cond_result got=%h want=%h", got, e); end
          if (b && exp_br < CMAX) exp_br++;
          if (e.mp && exp_mp < CMAX) exp_mp++;
        end
      end
      if (idx < rq.size()) apply(rq[idx], 1'b1); else apply('0, 1'b0);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(rq[idx])); bq.push_back(rq[idx].op != 2'b11); idx++;
      end
    end
    checks++;
    if (idx != rq.size() || sb.size() != 0) begin
      errors++; $display("FAIL cond_timeout sent=%0d pending=%0d want %0d 0", idx, sb.size(), rq.size());
    end
    @(negedge clk); #1;
    checks++;
    if (bus.br_count !== CW'(exp_br) || bus.mp_count !== CW'(exp_mp)) begin
      errors++; $display("FAIL cond_counters br=%0d mp=%0d want %0d %0d",
                         bus.br_count, bus.mp_count, exp_br, exp_mp);
    end
  endtask

  // Four beq requests with the consumer stalling from the third cycle
  task automatic test_back_to_back();
    req_t rq[$];
    res_t e, got, held;
    logic b, held_v;
    int idx;
    do_reset();
    rq.push_back(mk(2'b00, 3'b000, 32'h7, 32'h7, 32'h500, 32'h10, 1'b1, 32'h510));
    rq.push_back(mk(2'b00, 3'b000, 32'h7, 32'h8, 32'h504, 32'h10, 1'b0, 32'h0));
    rq.push_back(mk(2'b00, 3'b000, 32'h0, 32'h0, 32'h508, 32'h100, 1'b0, 32'h0));
    rq.push_back(mk(2'b00, 3'b000, 32'h1, 32'h2, 32'h50C, 32'h10, 1'b1, 32'h51C));
    idx = 0; held_v = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && (idx < rq.size() || sb.size() != 0); cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 2 && cyc < 7); #1;
      got = observed();
      if (bus.out_valid && !bus.out_ready) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready got=%b want=0", bus.in_ready); end
        if (held_v) begin
          checks++;
          if (got !== held) begin errors++; $display("FAIL b2b_stable got=%h want=%h", got, held); end
        end
        held = got; held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got=%h want=none", got);
        end else begin
          e = sb.pop_front(); b = bq.pop_front();
          if (got !== e) begin errors++; $display("FAIL b2b_result got=%h want=%h", got, e); end
          if (b && exp_br < CMAX) exp_br++;
          if (e.mp && exp_mp < CMAX) exp_mp++;
        end
      end
      if (idx < rq.size()) apply(rq[idx], 1'b1); else apply('0, 1'b0);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(rq[idx])); bq.push_back(1'b1); idx++;
      end
    end
    checks++;
    if (idx != rq.size() || sb.size() != 0) begin
      errors++; $display("FAIL b2b_timeout sent=%0d pending=%0d want 4 0", idx, sb.size());
    end
    @(negedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.br_count !== CW'(exp_br) || bus.mp_count !== CW'(exp_mp)) begin
      errors++; $display("FAIL b2b_tail ov=%b br=%0d mp=%0d want 0 %0d %0d",
                         bus.out_valid, bus.br_count, bus.mp_count, exp_br, exp_mp);
    end
  endtask

  // Flush with two requests in flight and a third being presented
  task automatic test_flush();
    do_reset();
    @(negedge clk);
    apply(mk(2'b00, 3'b000, 32'h1, 32'h1, 32'h700, 32'h8, 1'b0, 32'h0), 1'b1);
    @(negedge clk);
    apply(mk(2'b01, 3'b000, 32'h0, 32'h0, 32'h704, 32'h8, 1'b0, 32'h0), 1'b1);
    @(negedge clk);
    apply(mk(2'b10, 3'b000, 32'h800, 32'h0, 32'h708, 32'h4, 1'b0, 32'h0), 1'b1);
    bus.flush = 1'b1; #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_precond out_valid got=%b want=1", bus.out_valid); end
    @(negedge clk);
    bus.flush = 1'b0;
    apply('0, 1'b0); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_next out_valid got=%b want=0", bus.out_valid); end
    repeat (4) begin
      @(negedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak out_valid got=%b want=0", bus.out_valid); end
    end
    checks++;
    if (bus.br_count !== '0 || bus.mp_count !== '0) begin
      errors++; $display("FAIL flush_counters br=%0d mp=%0d want 0 0", bus.br_count, bus.mp_count);
    end
  endtask

  // 17 mispredicting branches saturate both counters; illegal functs follow
  task automatic test_saturation();
    req_t rq[$];
    res_t e, got;
    logic b;
    int idx;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      rq.push_back(mk(2'b00, 3'b000, 32'h3, 32'h3, 32'h600 + 32'(4 * i), 32'h8, 1'b0, 32'h0));
    end
    rq.push_back(mk(2'b00, 3'b010, 32'h3, 32'h3, 32'h900, 32'h8, 1'b1, 32'h908));
    rq.push_back(mk(2'b00, 3'b011, 32'h3, 32'h4, 32'h904, 32'h8, 1'b1, 32'h90C));
    idx = 0;
    for (int cyc = 0; cyc < 80 && (idx < rq.size() || sb.size() != 0); cyc++) begin
      @(negedge clk);
      bus.out_ready = 1'b1; #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        got = observed();
        if (sb.size() == 0) begin
          errors++; $display("FAIL sat_unexpected got=%h want=none", got);
        end else begin
          e = sb.pop_front(); b = bq.pop_front();
          if (got !== e) begin errors++; $display("FAIL sat_result got=%h want=%h", got, e); end
          if (b && exp_br < CMAX) exp_br++;
          if (e.mp && exp_mp < CMAX) exp_mp++;
        end
      end
      if (idx < rq.size()) apply(rq[idx], 1'b1); else apply('0, 1'b0);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(rq[idx])); bq.push_back(1'b1); idx++;
      end
    end
    checks++;
    if (idx != rq.size() || sb.size() != 0) begin
      errors++; $display("FAIL sat_timeout sent=%0d pending=%0d want %0d 0", idx, sb.size(), rq.size());
    end
    @(negedge clk); #1;
    checks++;
    if (bus.illegal !== 1'b1 || bus.taken !== 1'b0 || bus.mispredict !== 1'b0) begin
      errors++; $display("FAIL sat_illegal ill=%b taken=%b mp=%b want 1 0 0",
                         bus.illegal, bus.taken, bus.mispredict);
    end
    checks++;
    if (bus.br_count !== 4'd15 || bus.mp_count !== 4'd15) begin
      errors++; $display("FAIL sat_counters br=%0d mp=%0d want 15 15", bus.br_count, bus.mp_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    apply('0, 1'b0);
    test_reset();
    test_single();
    test_conditions();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
